// File: rtl/lavadora_pkg.sv
//------------------------------------------------------------------------------
// Module   : lavadora_pkg
// Purpose  : Types and default timing shared by the wash controller and plant.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lavadora_pkg;

  localparam int DIV_DEF            = 4;
  localparam int NIVEL_W_DEF        = 8;
  localparam int NIVEL_CHEIO_DEF    = 200;
  localparam int PASSO_ENCHER_DEF   = 10;
  localparam int PASSO_ESVAZIAR_DEF = 20;
  localparam int T_AGITAR_DEF       = 30;
  localparam int T_GIRAR_DEF        = 20;
  localparam int T_ENCHER_MAX_DEF   = 40;

  typedef struct packed {
    logic valvula_agua;
    logic modo_agitar;
    logic modo_girar;
  } cmd_t;

  typedef struct packed {
    logic cheio;
    logic tempo;
    logic secar;
  } sensor_t;

  typedef enum logic [1:0] {
    espera = 2'd0,
    encher = 2'd1,
    agitar = 2'd2,
    girar  = 2'd3
  } estado_t;

  function automatic logic mais_de_um(input cmd_t c);
    return (c.valvula_agua & c.modo_agitar) |
           (c.valvula_agua & c.modo_girar)  |
           (c.modo_agitar  & c.modo_girar);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lavadora_sensores_divisor_tick.sv
//------------------------------------------------------------------------------
// Module   : divisor_tick
// Purpose  : Prescaler producing a one-cycle tick every DIV clock cycles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module divisor_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  generate
    if (DIV <= 1) begin : g_div_um
      logic w_unused_div;
      assign w_unused_div = clk ^ rst;
      assign tick = 1'b1;
    end else begin : g_div_n
      localparam int CW = $clog2(DIV);
      localparam logic [CW-1:0] C_ULTIMO = CW'(DIV - 1);

      logic [CW-1:0] cont_div_q;
      logic [CW-1:0] cont_div_d;

      always_comb begin
        cont_div_d = cont_div_q + 1'b1;
        if (cont_div_q == C_ULTIMO) cont_div_d = '0;
      end

      always_ff @(posedge clk) begin
        if (rst) cont_div_q <= '0;
        else     cont_div_q <= cont_div_d;
      end

      assign tick = (cont_div_q == C_ULTIMO);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/lavadora_sensores.sv
//------------------------------------------------------------------------------
// Module   : lavadora_sensores
// Purpose  : Washing-machine drum plant model: water level plus agitate/spin
//            timers driving the controller's sensor inputs. Optional fault
//            detection is enabled by defining LAVADORA_ERRO_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lavadora_sensores
  import lavadora_pkg::*;
#(
  parameter int DIV            = DIV_DEF,
  parameter int NIVEL_W        = NIVEL_W_DEF,
  parameter int NIVEL_CHEIO    = NIVEL_CHEIO_DEF,
  parameter int PASSO_ENCHER   = PASSO_ENCHER_DEF,
  parameter int PASSO_ESVAZIAR = PASSO_ESVAZIAR_DEF,
  parameter int T_AGITAR       = T_AGITAR_DEF,
  parameter int T_GIRAR        = T_GIRAR_DEF,
  parameter int T_ENCHER_MAX   = T_ENCHER_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valvula_agua,
  input  logic               modo_agitar,
  input  logic               modo_girar,
  output logic               cheio,
  output logic               tempo,
  output logic               secar,
  output logic [NIVEL_W-1:0] nivel,
  output logic               erro
);

  localparam int AG_W = $clog2(T_AGITAR + 1);
  localparam int GI_W = $clog2(T_GIRAR + 1);

  localparam logic [AG_W-1:0]    C_T_AGITAR       = AG_W'(T_AGITAR);
  localparam logic [GI_W-1:0]    C_T_GIRAR        = GI_W'(T_GIRAR);
  localparam logic [NIVEL_W-1:0] C_NIVEL_CHEIO    = NIVEL_W'(NIVEL_CHEIO);
  localparam logic [NIVEL_W:0]   C_NIVEL_MAX      = {1'b0, {NIVEL_W{1'b1}}};
  localparam logic [NIVEL_W:0]   C_PASSO_ENCHER   = (NIVEL_W+1)'(PASSO_ENCHER);
  localparam logic [NIVEL_W:0]   C_PASSO_ESVAZIAR = (NIVEL_W+1)'(PASSO_ESVAZIAR);

  logic w_tick;

  divisor_tick #(.DIV(DIV)) u_divisor_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  logic [NIVEL_W-1:0] nivel_q, nivel_d;
  logic [NIVEL_W:0]   w_soma, w_dif;
  logic [AG_W-1:0]    ag_q, ag_d;
  logic [GI_W-1:0]    gi_q, gi_d;

  // Extra MSB holds the carry on fill and the borrow on drain.
  always_comb begin
    w_soma  = {1'b0, nivel_q} + C_PASSO_ENCHER;
    w_dif   = {1'b0, nivel_q} - C_PASSO_ESVAZIAR;
    nivel_d = nivel_q;
    if (w_tick) begin
      if (valvula_agua && !modo_girar)
        nivel_d = (w_soma > C_NIVEL_MAX) ? '1 : w_soma[NIVEL_W-1:0];
      else if (modo_girar && !valvula_agua)
        nivel_d = w_dif[NIVEL_W] ? '0 : w_dif[NIVEL_W-1:0];
    end
  end

  always_comb begin
    ag_d = '0;
    if (modo_agitar) begin
      ag_d = ag_q;
      if (w_tick && ag_q != C_T_AGITAR) ag_d = ag_q + 1'b1;
    end
    gi_d = '0;
    if (modo_girar) begin
      gi_d = gi_q;
      if (w_tick && gi_q != C_T_GIRAR) gi_d = gi_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nivel_q <= '0;
      ag_q    <= '0;
      gi_q    <= '0;
    end else begin
      nivel_q <= nivel_d;
      ag_q    <= ag_d;
      gi_q    <= gi_d;
    end
  end

  assign nivel = nivel_q;
  assign cheio = (nivel_q >= C_NIVEL_CHEIO);
  assign tempo = (ag_q == C_T_AGITAR);
  assign secar = !((gi_q == C_T_GIRAR) && (nivel_q == '0));

`ifdef LAVADORA_ERRO_EN
  localparam int EN_W = $clog2(T_ENCHER_MAX + 1);
  localparam logic [EN_W-1:0] C_T_ENCHER_MAX = EN_W'(T_ENCHER_MAX);

  cmd_t            w_cmd;
  logic [EN_W-1:0] enc_q, enc_d;
  logic            erro_q, erro_d;

  assign w_cmd = {valvula_agua, modo_agitar, modo_girar};

  always_comb begin
    enc_d = '0;
    if (valvula_agua && !cheio) begin
      enc_d = enc_q;
      if (w_tick && enc_q != C_T_ENCHER_MAX) enc_d = enc_q + 1'b1;
    end
    erro_d = erro_q | mais_de_um(w_cmd) | (enc_q == C_T_ENCHER_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_q  <= '0;
      erro_q <= 1'b0;
    end else begin
      enc_q  <= enc_d;
      erro_q <= erro_d;
    end
  end

  assign erro = erro_q;
`else
  logic w_unused_enc;
  assign w_unused_enc = |32'(T_ENCHER_MAX);
  assign erro = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lavadora_sensores.sv
//------------------------------------------------------------------------------
// Module   : tb_lavadora_sensores
// Purpose  : Directed, scoreboard-checked bench for the drum plant model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lavadora_sensores;

  localparam int DIV = 4;
  localparam int NW  = 8;
  localparam int NC  = 200;
  localparam int PE  = 10;
  localparam int PV  = 20;
  localparam int TA  = 30;
  localparam int TG  = 20;
  localparam int TE  = 40;
  localparam int NMAX = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          v = 1'b0, a = 1'b0, g = 1'b0;
  logic          cheio, tempo, secar, erro;
  logic [NW-1:0] nivel;

  int n_chk = 0;
  int n_err = 0;

  int m_div = 0, m_nivel = 0, m_ag = 0, m_gi = 0, m_enc = 0;
  bit m_erro = 1'b0;
  logic [11:0] sb_q[$];

  always #5 clk = ~clk;

  lavadora_sensores #(
    .DIV(DIV), .NIVEL_W(NW), .NIVEL_CHEIO(NC), .PASSO_ENCHER(PE),
    .PASSO_ESVAZIAR(PV), .T_AGITAR(TA), .T_GIRAR(TG), .T_ENCHER_MAX(TE)
  ) dut (
    .clk(clk), .rst(rst), .valvula_agua(v), .modo_agitar(a), .modo_girar(g),
    .cheio(cheio), .tempo(tempo), .secar(secar), .nivel(nivel), .erro(erro)
  );

  function automatic logic [11:0] exp_out();
    logic [NW-1:0] n8;
    n8 = NW'(m_nivel);
    return {m_nivel >= NC, m_ag == TA, !(m_gi == TG && m_nivel == 0), n8, m_erro};
  endfunction

  // Reference behaviour of one clock edge, from the state before that edge.
  task automatic model_edge(input bit r, input bit vv, input bit aa, input bit gg);
    int od, on, oa, og, oe;
    bit tk;
    od = m_div; on = m_nivel; oa = m_ag; og = m_gi; oe = m_enc;
    tk = (od == DIV - 1);
    if (r) begin
      m_div = 0; m_nivel = 0; m_ag = 0; m_gi = 0; m_enc = 0; m_erro = 1'b0;
    end else begin
      if (tk) begin
        if (vv && !gg)      m_nivel = (on + PE > NMAX) ? NMAX : on + PE;
        else if (gg && !vv) m_nivel = (on < PV) ? 0 : on - PV;
      end
      m_ag = !aa ? 0 : ((tk && oa < TA) ? oa + 1 : oa);
      m_gi = !gg ? 0 : ((tk && og < TG) ? og + 1 : og);
`ifdef LAVADORA_ERRO_EN
      if (int'(vv) + int'(aa) + int'(gg) > 1 || oe == TE) m_erro = 1'b1;
      m_enc = (vv && on < NC) ? ((tk && oe < TE) ? oe + 1 : oe) : 0;
`endif
      m_div = (od == DIV - 1) ? 0 : od + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input bit r, input bit vv, input bit aa, input bit gg);
    logic [11:0] e;
    rst = r; v = vv; a = aa; g = gg;
    model_edge(r, vv, aa, gg);
    sb_q.push_back(exp_out());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("saidas", {20'd0, cheio, tempo, secar, nivel, erro}, {20'd0, e});
  endtask

  task automatic run(input int n, input bit vv, input bit aa, input bit gg);
    repeat (n) step(1'b0, vv, aa, gg);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1;
    do_reset();
    chk("rst_nivel", nivel, 0);
    chk("rst_cheio", cheio, 0);
    chk("rst_tempo", tempo, 0);
    chk("rst_secar", secar, 1);
    chk("rst_erro",  erro,  0);

    // Fill from empty: full after tick 20, saturate at 255.
    run(79, 1, 0, 0);
    chk("enche79_cheio", cheio, 0);
    chk("enche79_nivel", nivel, 190);
    run(1, 1, 0, 0);
    chk("enche80_cheio", cheio, 1);
    chk("enche80_nivel", nivel, 200);
    run(24, 1, 0, 0);
    chk("satura_nivel", nivel, 255);
    run(16, 1, 0, 0);
    chk("satura_mantem", nivel, 255);

    // Agitate: elapsed after 30 ticks, cleared on the edge after drop.
    run(119, 0, 1, 0);
    chk("agita119_tempo", tempo, 0);
    run(1, 0, 1, 0);
    chk("agita120_tempo", tempo, 1);
    run(80, 0, 1, 0);
    chk("agita_mantem", tempo, 1);
    run(1, 0, 0, 0);
    chk("agita_limpa", tempo, 0);

    // Spin from 200: empty after 10 ticks, secar drops after 20 ticks.
    do_reset();
    run(80, 1, 0, 0);
    chk("gira_inicio", nivel, 200);
    run(39, 0, 0, 1);
    chk("gira39_nivel", nivel, 20);
    run(1, 0, 0, 1);
    chk("gira40_nivel", nivel, 0);
    run(39, 0, 0, 1);
    chk("gira79_secar", secar, 1);
    run(1, 0, 0, 1);
    chk("gira80_secar", secar, 0);
    run(1, 0, 0, 0);
    chk("gira_solta_secar", secar, 1);

    // Drain floors at zero.
    do_reset();
    run(4, 1, 0, 0);
    chk("piso_inicio", nivel, 10);
    run(4, 0, 0, 1);
    chk("piso_zero", nivel, 0);
    run(4, 0, 0, 1);
    chk("piso_mantem", nivel, 0);

    // Reset mid-agitate at full drum; prescaler must restart.
    do_reset();
    run(80, 1, 0, 0);
    run(50, 0, 1, 0);
    chk("meio_nivel", nivel, 200);
    do_reset();
    chk("meio_rst_nivel", nivel, 0);
    chk("meio_rst_cheio", cheio, 0);
    chk("meio_rst_tempo", tempo, 0);
    chk("meio_rst_secar", secar, 1);
    run(3, 1, 0, 0);
    chk("div_reinicia3", nivel, 0);
    run(1, 1, 0, 0);
    chk("div_reinicia4", nivel, 10);

    // Conflicting commands.
    run(1, 1, 1, 0);
`ifdef LAVADORA_ERRO_EN
    chk("conflito_erro", erro, 1);
    run(5, 0, 0, 0);
    chk("conflito_pegajoso", erro, 1);
`else
    chk("conflito_erro", erro, 0);
    run(5, 0, 0, 0);
    chk("conflito_mantem", erro, 0);
`endif
    do_reset();
    chk("conflito_rst", erro, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
